serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 132 +++++++++++++
 tb/tb_serial_subtractor.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor
// Bit-serial unsigned subtractor: computes (a - b - bin) one bit per clock,
// LSB first, and reports the WIDTH-bit difference plus the final borrow.
//
// Timing with start accepted at edge 0:
//   edges 1..WIDTH   : state RUN, one bit processed per edge
//   edge WIDTH       : last bit processed, result/borrow loaded, state DONE
//   edge WIDTH+1     : back to IDLE
//   edge WIDTH+2     : earliest next accepted start (period WIDTH+2)
//
// WIDTH is meant to be in the range 2..32.

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    // Counter only has to reach WIDTH-1; keep at least one bit for WIDTH=2.
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Operand captures shift right so the bit under work is always at [0].
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    // Result bits enter at the MSB; after WIDTH shifts bit 0 sits at [0].
    logic [WIDTH-1:0] res_sr;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             a_i;
    logic             b_i;
    logic             d_bit;
    logic             br_nxt;
    logic             last_bit;
    logic [WIDTH-1:0] res_nxt;

    // One-bit full subtractor slice on the current LSBs.
    always_comb begin
        a_i      = a_sr[0];
        b_i      = b_sr[0];
        d_bit    = a_i ^ b_i ^ br;
        br_nxt   = (~a_i & b_i) | (~a_i & br) | (b_i & br);
        last_bit = (cnt == LAST_IDX);
        // Includes the bit being produced this edge so diff gets it too.
        res_nxt  = {d_bit, res_sr[WIDTH-1:1]};
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; start is only looked at in IDLE.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start)    state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs decode the registered state, so they are never both high.
    assign busy = (state == RUN);
    assign done = (state == DONE);

    // Datapath: capture on accepted start, shift/accumulate in RUN,
    // publish result and borrow on the edge that enters DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            bout   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        br     <= bin;
                        res_sr <= '0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_nxt;
                    br     <= br_nxt;
                    cnt    <= cnt + 1'b1;
                    if (last_bit) begin
                        diff <= res_nxt;
                        bout <= br_nxt;
                    end
                end
                DONE: begin
                    cnt <= '0;
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
// Directed vector table, back-to-back and mid-run reset sequences, and
// randomized operands checked against an integer-arithmetic reference.

module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;

    int checks   = 0;
    int failures = 0;

    // Last result the bench expects the DUT to be holding.
    logic [W-1:0] last_d;
    logic         last_bo;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] d;
        logic         bo;
    } vec_t;

    vec_t vecs[10];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case anything wedges.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic, borrow = result went negative.
    function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
        int xi, yi, ci, s;
        xi = x;
        yi = y;
        ci = c;
        s  = xi - yi - ci;
        ref_sub = {(s < 0), W'(s & ((1 << W) - 1))};
    endfunction

    // Starts at a negedge in IDLE, ends at a negedge back in IDLE.
    // scramble keeps start high and changes operands while the op runs.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin,
                          input bit scramble, input logic [W-1:0] ed, input logic ebo);
        a     = ta;
        b     = tb_v;
        bin   = tbin;
        start = 1'b1;
        @(posedge clk);
        for (int k = 0; k < W; k++) begin
            @(negedge clk);
            chk("run_busy_done", {30'd0, busy, done}, 32'b10);
            chk("run_hold", {23'd0, bout, diff}, {23'd0, last_bo, last_d});
            if (scramble) begin
                a     = W'($urandom);
                b     = W'($urandom);
                bin   = 1'($urandom);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
        end
        @(negedge clk);
        chk("done_busy_done", {30'd0, busy, done}, 32'b01);
        chk("done_diff", {24'd0, diff}, {24'd0, ed});
        chk("done_bout", {31'd0, bout}, {31'd0, ebo});
        last_d  = ed;
        last_bo = ebo;
        @(posedge clk);
        @(negedge clk);
        chk("idle_busy_done", {30'd0, busy, done}, 32'b00);
        chk("idle_hold", {23'd0, bout, diff}, {23'd0, last_bo, last_d});
    endtask

    initial begin
        logic [W:0] r;
        logic [W-1:0] ra, rb;
        logic         rc;
        bit           saw_done;

        vecs[0] = '{8'h50, 8'h20, 1'b0, 8'h30, 1'b0};
        vecs[1] = '{8'h20, 8'h50, 1'b0, 8'hD0, 1'b1};
        vecs[2] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
        vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[4] = '{8'h80, 8'h00, 1'b1, 8'h7F, 1'b0};
        vecs[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[6] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
        vecs[7] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0};
        vecs[8] = '{8'hFF, 8'hFE, 1'b1, 8'h00, 1'b0};
        vecs[9] = '{8'h01, 8'h00, 1'b1, 8'h00, 1'b0};

        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        last_d  = '0;
        last_bo = 1'b0;

        // Reset state.
        #12;
        chk("reset_busy_done", {30'd0, busy, done}, 32'b00);
        chk("reset_diff_bout", {23'd0, bout, diff}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Start low in IDLE: nothing happens.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("idle_no_start", {30'd0, busy, done}, 32'b00);
        end

        // Directed table.
        for (int i = 0; i < 10; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].bin, 1'b0, vecs[i].d, vecs[i].bo);

        // Back-to-back with start held high and operands churning.
        for (int i = 0; i < 6; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            r  = ref_sub(ra, rb, rc);
            run_op(ra, rb, rc, 1'b1, r[W-1:0], r[W]);
        end
        start = 1'b0;
        @(negedge clk);

        // Reset during the 4th RUN cycle aborts without a done pulse.
        a     = 8'h33;
        b     = 8'h11;
        bin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pre_abort_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_busy_done", {30'd0, busy, done}, 32'b00);
        chk("abort_diff_bout", {23'd0, bout, diff}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        last_d  = '0;
        last_bo = 1'b0;
        saw_done = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        chk("abort_no_done", {31'd0, saw_done}, 32'd0);
        run_op(8'h10, 8'h01, 1'b0, 1'b0, 8'h0F, 1'b0);

        // Random operands against the reference.
        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            r  = ref_sub(ra, rb, rc);
            run_op(ra, rb, rc, bit'($urandom_range(0, 1)), r[W-1:0], r[W]);
        end
        start = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
